// File: rtl/mem_access_if.sv
// Word-wide data-bus bundle between the load/store unit and the memory side.
// The master issues requests, and the slave answers with ack and read data.
interface mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access.sv
// RV32 load/store unit: turns one byte, halfword or word request into a single
// word-aligned bus transaction. Loads are written back with sign or zero extension.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   mem_load_mode,
    input  logic [31:0]  mem_load_addr,
    input  logic [4:0]   mem_load_dest_regs_addr,
    input  logic [1:0]   mem_store_mode,
    input  logic [31:0]  mem_store_addr,
    input  logic [31:0]  mem_store_data,
    output logic         busy,
    mem_access_if.master bus,
    output logic         regs_write_en,
    output logic [4:0]   regs_write_addr,
    output logic [31:0]  regs_write_data,
    output logic         err
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB} state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  ld_mode_q, ld_mode_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  rd_q, rd_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic        rwe_q, rwe_d;
    logic [4:0]  rwa_q, rwa_d;
    logic [31:0] rwd_q, rwd_d;
    logic        err_q, err_d;

    logic        load_valid, store_valid, load_bad, store_bad;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;

    function automatic logic [31:0] extend_load(input logic [2:0] mode,
                                                input logic [1:0] lo,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (mode)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {24'd0, b};
            3'b101:  extend_load = {16'd0, h};
            default: extend_load = rdata;
        endcase
    endfunction

    // Request decode; mode 011 and 110 are reserved load encodings.
    always_comb begin
        load_valid  = (mem_load_mode != 3'b111);
        store_valid = (mem_store_mode != 2'b00);
        load_bad    = (mem_load_mode == 3'b011) || (mem_load_mode == 3'b110)
                    || ((mem_load_mode[1:0] == 2'b01) && mem_load_addr[0])
                    || ((mem_load_mode[1:0] == 2'b10) && (mem_load_addr[1:0] != 2'b00));
        store_bad   = ((mem_store_mode == 2'b10) && mem_store_addr[0])
                    || ((mem_store_mode == 2'b11) && (mem_store_addr[1:0] != 2'b00));
    end

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = mem_store_data;
        case (mem_store_mode)
            2'b01: begin
                st_wstrb = 4'b0001 << mem_store_addr[1:0];
                st_wdata = {4{mem_store_data[7:0]}};
            end
            2'b10: begin
                st_wstrb = mem_store_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{mem_store_data[15:0]}};
            end
            2'b11:   st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        is_store_d  = is_store_q;
        ld_mode_d   = ld_mode_q;
        addr_lo_d   = addr_lo_q;
        rd_d        = rd_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        rwe_d       = 1'b0;
        rwa_d       = rwa_q;
        rwd_d       = rwd_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    // A load wins over a simultaneous store; the store is dropped.
                    err_d = load_bad || store_valid;
                    if (!load_bad) begin
                        state_d     = S_ACCESS;
                        wait_d      = '0;
                        is_store_d  = 1'b0;
                        ld_mode_d   = mem_load_mode;
                        addr_lo_d   = mem_load_addr[1:0];
                        rd_d        = mem_load_dest_regs_addr;
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = {mem_load_addr[31:2], 2'b00};
                        bus_wstrb_d = 4'b0000;
                    end
                end else if (store_valid) begin
                    err_d = store_bad;
                    if (!store_bad) begin
                        state_d     = S_ACCESS;
                        wait_d      = '0;
                        is_store_d  = 1'b1;
                        addr_lo_d   = mem_store_addr[1:0];
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b1;
                        bus_addr_d  = {mem_store_addr[31:2], 2'b00};
                        bus_wdata_d = st_wdata;
                        bus_wstrb_d = st_wstrb;
                    end
                end
            end
            S_ACCESS: begin
                if (bus.bus_ack) begin
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    if (is_store_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WB;
                        rwe_d   = (rd_q != 5'd0);
                        rwa_d   = rd_q;
                        rwd_d   = extend_load(ld_mode_q, addr_lo_q, bus.bus_rdata);
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = S_IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    err_d       = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            is_store_q  <= 1'b0;
            ld_mode_q   <= 3'b111;
            addr_lo_q   <= 2'b00;
            rd_q        <= 5'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_wstrb_q <= 4'b0000;
            rwe_q       <= 1'b0;
            rwa_q       <= 5'd0;
            rwd_q       <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            is_store_q  <= is_store_d;
            ld_mode_q   <= ld_mode_d;
            addr_lo_q   <= addr_lo_d;
            rd_q        <= rd_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            rwe_q       <= rwe_d;
            rwa_q       <= rwa_d;
            rwd_q       <= rwd_d;
            err_q       <= err_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign bus.bus_req     = bus_req_q;
    assign bus.bus_we      = bus_we_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wdata   = bus_wdata_q;
    assign bus.bus_wstrb   = bus_wstrb_q;
    assign regs_write_en   = rwe_q;
    assign regs_write_addr = rwa_q;
    assign regs_write_data = rwd_q;
    assign err             = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// load/store traffic compared against a byte-lane reference model.
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic [2:0]  mem_load_mode;
    logic [31:0] mem_load_addr;
    logic [4:0]  mem_load_dest_regs_addr;
    logic [1:0]  mem_store_mode;
    logic [31:0] mem_store_addr;
    logic [31:0] mem_store_data;
    logic        busy;
    logic        regs_write_en;
    logic [4:0]  regs_write_addr;
    logic [31:0] regs_write_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_access_if bus_if ();

    mem_access dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .mem_load_mode           (mem_load_mode),
        .mem_load_addr           (mem_load_addr),
        .mem_load_dest_regs_addr (mem_load_dest_regs_addr),
        .mem_store_mode          (mem_store_mode),
        .mem_store_addr          (mem_store_addr),
        .mem_store_data          (mem_store_data),
        .busy                    (busy),
        .bus                     (bus_if.master),
        .regs_write_en           (regs_write_en),
        .regs_write_addr         (regs_write_addr),
        .regs_write_data         (regs_write_data),
        .err                     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_load_mode           = 3'b111;
        mem_load_addr           = $urandom;
        mem_load_dest_regs_addr = 5'($urandom);
        mem_store_mode          = 2'b00;
        mem_store_addr          = $urandom;
        mem_store_data          = $urandom;
    endtask

    // Reference model: sizes in bytes, lanes by index, extension by masking.
    function automatic bit load_legal(input logic [2:0] m);
        return m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic int load_size(input logic [2:0] m);
        return 1 << m[1:0];
    endfunction

    function automatic int store_size(input logic [1:0] s);
        return 1 << (int'(s) - 1);
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] s, input logic [31:0] a);
        int n;
        n = store_size(s);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] s, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = store_size(s);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] m, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] v, mask;
        int n;
        n = load_size(m);
        v = rdata >> (8 * (a % 4));
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!m[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic do_txn(input logic [2:0] lmode, input logic [31:0] laddr, input logic [4:0] rd,
                          input logic [1:0] smode, input logic [31:0] saddr,
                          input logic [31:0] sdata, input int ack_dly, input logic [31:0] rdata);
        bit lv, sv, l_ok, s_ok, exp_err, stable;
        int kind, busy_cycles;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_wstrb;
        lv   = (lmode != 3'b111);
        sv   = (smode != 2'b00);
        l_ok = lv && load_legal(lmode) && ((laddr % load_size(lmode)) == 0);
        s_ok = sv && ((saddr % store_size(smode)) == 0);
        kind = 0;
        exp_err = 1'b0;
        if (lv) begin
            exp_err = !l_ok || sv;
            if (l_ok) kind = 1;
        end else if (sv) begin
            exp_err = !s_ok;
            if (s_ok) kind = 2;
        end
        exp_addr  = ((kind == 1) ? laddr : saddr) & 32'hFFFF_FFFC;
        exp_wstrb = (kind == 2) ? store_strb(smode, saddr) : 4'b0000;
        exp_wdata = store_data(smode, sdata);

        mem_load_mode           = lmode;
        mem_load_addr           = laddr;
        mem_load_dest_regs_addr = rd;
        mem_store_mode          = smode;
        mem_store_addr          = saddr;
        mem_store_data          = sdata;
        step();
        idle_inputs();
        check("accept_err", err, exp_err);

        if (kind == 0) begin
            check("reject_busy", busy, 0);
            check("reject_req", bus_if.bus_req, 0);
            bus_if.bus_ack = 1'b1;
            step();
            bus_if.bus_ack = 1'b0;
            check("reject_err_end", err, 0);
            check("reject_req2", bus_if.bus_req, 0);
            check("reject_wen", regs_write_en, 0);
            return;
        end

        check("access_busy", busy, 1);
        check("access_req", bus_if.bus_req, 1);
        check("access_addr", bus_if.bus_addr, exp_addr);
        check("access_we", bus_if.bus_we, (kind == 2));
        check("access_wstrb", bus_if.bus_wstrb, exp_wstrb);
        if (kind == 2) check("access_wdata", bus_if.bus_wdata, exp_wdata);

        busy_cycles = 1;
        stable = 1'b1;
        for (int k = 0; k < ack_dly; k++) begin
            bus_if.bus_rdata = $urandom;
            step();
            if (!(bus_if.bus_req && busy && (bus_if.bus_addr == exp_addr)
                  && (bus_if.bus_we == (kind == 2)) && (bus_if.bus_wstrb == exp_wstrb)
                  && !err && !regs_write_en))
                stable = 1'b0;
            if (busy) busy_cycles++;
        end
        check("access_stable", stable, 1);

        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
        step();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = $urandom;
        check("ack_req_low", bus_if.bus_req, 0);
        check("ack_err", err, 0);

        if (kind == 2) begin
            check("store_busy_end", busy, 0);
            check("store_wen", regs_write_en, 0);
            check("store_busy_cycles", busy_cycles, ack_dly + 1);
        end else begin
            check("wb_busy", busy, 1);
            check("wb_wen", regs_write_en, (rd != 5'd0));
            if (rd != 5'd0) begin
                check("wb_rd", regs_write_addr, rd);
                check("wb_data", regs_write_data, model_load(lmode, laddr, rdata));
            end
            step();
            check("wb_wen_end", regs_write_en, 0);
            check("wb_busy_end", busy, 0);
        end
    endtask

    initial begin
        int cnt;
        logic [2:0] legal_modes [5];
        logic [2:0] lm;
        logic [1:0] sm;
        int r;
        legal_modes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst_n = 1'b0;
        idle_inputs();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_req", bus_if.bus_req, 0);
        check("rst_we", bus_if.bus_we, 0);
        check("rst_addr", bus_if.bus_addr, 0);
        check("rst_wdata", bus_if.bus_wdata, 0);
        check("rst_wstrb", bus_if.bus_wstrb, 0);
        check("rst_wen", regs_write_en, 0);
        check("rst_waddr", regs_write_addr, 0);
        check("rst_wdata_reg", regs_write_data, 0);
        check("rst_err", err, 0);
        #3;
        rst_n = 1'b1;

        // SB on the first edge after reset release, acked after two cycles
        do_txn(3'b111, 32'h0, 5'd0, 2'b01, 32'h0000_1003, 32'h0000_00A5, 2, 32'h0);
        // LB / LBU sign vs zero extension
        do_txn(3'b000, 32'h0000_2001, 5'd5, 2'b00, 32'h0, 32'h0, 1, 32'h0000_8000);
        do_txn(3'b100, 32'h0000_2001, 5'd5, 2'b00, 32'h0, 32'h0, 1, 32'h0000_8000);
        // Misaligned LW, then LH to x0
        do_txn(3'b010, 32'h0000_3002, 5'd7, 2'b00, 32'h0, 32'h0, 0, 32'h0);
        do_txn(3'b001, 32'h0000_3002, 5'd0, 2'b00, 32'h0, 32'h0, 0, 32'h1234_0000);
        // Load and store together
        do_txn(3'b010, 32'h0000_4000, 5'd7, 2'b11, 32'h0000_5000, 32'hDEAD_BEEF, 1, 32'hCAFE_F00D);
        // Illegal funct3, misaligned SH and SW
        do_txn(3'b011, 32'h0000_4000, 5'd3, 2'b00, 32'h0, 32'h0, 0, 32'h0);
        do_txn(3'b111, 32'h0, 5'd0, 2'b10, 32'h0000_5001, 32'h1234_5678, 0, 32'h0);
        do_txn(3'b111, 32'h0, 5'd0, 2'b11, 32'h0000_5002, 32'h1234_5678, 0, 32'h0);

        // Load with no ack ever: timeout
        mem_load_mode           = 3'b010;
        mem_load_addr           = 32'h0000_7000;
        mem_load_dest_regs_addr = 5'd9;
        step();
        idle_inputs();
        cnt = 0;
        while (bus_if.bus_req && cnt < 400) begin
            cnt++;
            step();
        end
        check("timeout_req_cycles", cnt, 255);
        check("timeout_err", err, 1);
        check("timeout_busy", busy, 0);
        check("timeout_wen", regs_write_en, 0);
        step();
        check("timeout_err_end", err, 0);
        check("timeout_wen_end", regs_write_en, 0);

        // Reset pulse in the middle of ACCESS
        mem_load_mode           = 3'b010;
        mem_load_addr           = 32'h0000_6000;
        mem_load_dest_regs_addr = 5'd3;
        step();
        idle_inputs();
        check("mid_rst_req_before", bus_if.bus_req, 1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", bus_if.bus_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", bus_if.bus_addr, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h5555_AAAA;
        step();
        check("post_rst_wen", regs_write_en, 0);
        check("post_rst_err", err, 0);
        check("post_rst_req", bus_if.bus_req, 0);
        step();
        bus_if.bus_ack = 1'b0;
        check("post_rst_wen2", regs_write_en, 0);
        check("post_rst_busy", busy, 0);
        do_txn(3'b101, 32'h0000_6002, 5'd12, 2'b00, 32'h0, 32'h0, 0, 32'hBEEF_0123);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            r  = $urandom_range(0, 9);
            lm = legal_modes[$urandom_range(0, 4)];
            sm = 2'($urandom_range(1, 3));
            case (r)
                0, 1, 2, 3: do_txn(lm, $urandom, 5'($urandom), 2'b00, $urandom, $urandom,
                                   $urandom_range(0, 4), $urandom);
                4, 5, 6:    do_txn(3'b111, $urandom, 5'($urandom), sm, $urandom, $urandom,
                                   $urandom_range(0, 4), $urandom);
                7:          do_txn(lm, $urandom, 5'($urandom), sm, $urandom, $urandom,
                                   $urandom_range(0, 4), $urandom);
                8:          do_txn(3'b111, $urandom, 5'($urandom), 2'b00, $urandom, $urandom,
                                   0, $urandom);
                default:    do_txn(($urandom_range(0, 1) != 0) ? 3'b011 : 3'b110, $urandom,
                                   5'($urandom), 2'b00, $urandom, $urandom, 0, $urandom);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
